// File: rtl/clkdiv_cfg_ctrl.sv
// Divider config sequencer: applies ratio changes/shutdowns only on divided-period boundaries.
// Latency: OFF requests apply in 1 cycle; RUN changes take up to eff + GAP_CYCLES + 1 cycles.
// Backpressure: o_req_ready low in DRAIN/GAP. Optional CLKDIV_CFG_ERR_EN rejects ratio-0 requests.
module clkdiv_cfg_ctrl #(
    parameter int          RATIO_W    = 8,
    parameter int          GAP_CYCLES = 2,
    parameter int unsigned RST_RATIO  = 4
) (
    input  logic               i_ref_clk,
    input  logic               i_rst,
    input  logic               i_div_en,
    input  logic               i_req_valid,
    input  logic [RATIO_W-1:0] i_req_ratio,
    output logic               o_req_ready,
    output logic               o_clk_en,
    output logic [RATIO_W-1:0] o_dev_ratio,
    output logic               o_busy,
    output logic               o_cfg_done,
    output logic               o_req_err
);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);

    state_t             state_q, state_d;
    logic [RATIO_W-1:0] cnt_q, cnt_d;
    logic [3:0]         gap_cnt_q, gap_cnt_d;
    logic [RATIO_W-1:0] pend_ratio_q, pend_ratio_d;
    logic               pend_ratio_f_q, pend_ratio_f_d;
    logic               pend_off_f_q, pend_off_f_d;
    logic               clk_en_q, clk_en_d;
    logic [RATIO_W-1:0] dev_ratio_q, dev_ratio_d;
    logic               req_ready_q, req_ready_d;
    logic               busy_q, busy_d;
    logic               cfg_done_q, cfg_done_d;
    logic               req_err_q, req_err_d;

    logic [RATIO_W-1:0] eff;
    logic               boundary;
    logic               accept;
    logic               req_bad;
    logic               req_ok;

    always_comb begin
        eff      = (dev_ratio_q < RATIO_W'(2)) ? RATIO_W'(1) : dev_ratio_q;
        boundary = (cnt_q == (eff - RATIO_W'(1)));
        accept   = i_req_valid & req_ready_q;
`ifdef CLKDIV_CFG_ERR_EN
        req_bad  = accept & (i_req_ratio == '0);
`else
        req_bad  = 1'b0;
`endif
        req_ok   = accept & ~req_bad;
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        gap_cnt_d      = gap_cnt_q;
        pend_ratio_d   = pend_ratio_q;
        pend_ratio_f_d = pend_ratio_f_q;
        pend_off_f_d   = pend_off_f_q;
        dev_ratio_d    = dev_ratio_q;
        cfg_done_d     = 1'b0;
        req_err_d      = req_bad;

        // Phase counter only advances while the divider is enabled.
        if (clk_en_q) begin
            cnt_d = boundary ? '0 : cnt_q + RATIO_W'(1);
        end

        case (state_q)
            ST_OFF: begin
                if (req_ok) begin
                    dev_ratio_d = i_req_ratio;
                    cfg_done_d  = 1'b1;
                end
                if (i_div_en) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                if (req_ok) begin
                    if (i_req_ratio == dev_ratio_q) begin
                        cfg_done_d = 1'b1;
                    end else begin
                        pend_ratio_d   = i_req_ratio;
                        pend_ratio_f_d = 1'b1;
                        state_d        = ST_DRAIN;
                    end
                end
                if (!i_div_en) begin
                    pend_off_f_d = 1'b1;
                    state_d      = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                pend_off_f_d = ~i_div_en;
                if (boundary) begin
                    state_d   = ST_GAP;
                    cnt_d     = '0;
                    gap_cnt_d = GAP_LOAD;
                    if (pend_ratio_f_q) begin
                        dev_ratio_d = pend_ratio_q;
                        cfg_done_d  = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == 4'd0) begin
                    pend_ratio_f_d = 1'b0;
                    pend_off_f_d   = 1'b0;
                    state_d        = (pend_off_f_q || !i_div_en) ? ST_OFF : ST_RUN;
                end else begin
                    gap_cnt_d = gap_cnt_q - 4'd1;
                end
            end
            default: state_d = ST_OFF;
        endcase

        // Registered outputs are derived from the next state so they line up with it.
        clk_en_d    = (state_d == ST_RUN) || (state_d == ST_DRAIN);
        busy_d      = (state_d == ST_DRAIN) || (state_d == ST_GAP);
        req_ready_d = (state_d == ST_OFF) || (state_d == ST_RUN);
    end

    always_ff @(posedge i_ref_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q        <= ST_OFF;
            cnt_q          <= '0;
            gap_cnt_q      <= '0;
            pend_ratio_q   <= '0;
            pend_ratio_f_q <= 1'b0;
            pend_off_f_q   <= 1'b0;
            clk_en_q       <= 1'b0;
            dev_ratio_q    <= RATIO_W'(RST_RATIO);
            req_ready_q    <= 1'b0;
            busy_q         <= 1'b0;
            cfg_done_q     <= 1'b0;
            req_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            gap_cnt_q      <= gap_cnt_d;
            pend_ratio_q   <= pend_ratio_d;
            pend_ratio_f_q <= pend_ratio_f_d;
            pend_off_f_q   <= pend_off_f_d;
            clk_en_q       <= clk_en_d;
            dev_ratio_q    <= dev_ratio_d;
            req_ready_q    <= req_ready_d;
            busy_q         <= busy_d;
            cfg_done_q     <= cfg_done_d;
            req_err_q      <= req_err_d;
        end
    end

    assign o_req_ready = req_ready_q;
    assign o_clk_en    = clk_en_q;
    assign o_dev_ratio = dev_ratio_q;
    assign o_busy      = busy_q;
    assign o_cfg_done  = cfg_done_q;
    assign o_req_err   = req_err_q;

endmodule

// File: doc/clkdiv_cfg_ctrl.md
Name: clkdiv_cfg_ctrl

Overview:
Configuration sequencer for the integer clock divider.
- Accepts ratio-change requests and enable/disable requests from the system control path.
- Drives the divider's clock enable and ratio inputs so that ratio changes and shutdowns happen only at a divided-period boundary. This prevents truncated or glitched divided-clock periods.
- Sits between the register file / system controller and the divider, in the reference clock domain.

Parameters:
- RATIO_W, 8, width of the ratio bus (matches divider ratio width).
- GAP_CYCLES, 2, ref-clock cycles the divider enable is held low while a new ratio is loaded; legal range 1..15.
- RST_RATIO, 4, value of o_dev_ratio after reset.

Ports:
- i_ref_clk  in  1  reference clock; same clock as the divider.
- i_rst  in  1  reset, asynchronous, active-high.
- i_div_en  in  1  level request: divided clock wanted running.
- i_req_valid  in  1  ratio-change request valid.
- i_req_ratio  in  RATIO_W  requested division ratio.
- o_req_ready  out  1  request accepted on a cycle where valid and ready are both high.
- o_clk_en  out  1  to divider clock enable.
- o_dev_ratio  out  RATIO_W  to divider ratio input.
- o_busy  out  1  high in DRAIN or GAP.
- o_cfg_done  out  1  one-cycle pulse when a ratio is applied.
- o_req_err  out  1  one-cycle pulse on a rejected request (macro only; tied 0 otherwise).

Behaviour:
- All outputs are registered.
- Reset values: o_clk_en=0, o_dev_ratio=RST_RATIO, o_req_ready=0, o_busy=0, o_cfg_done=0, o_req_err=0. State=OFF, cnt=0, pending flags cleared.
- Assertion of i_rst at any time, including mid-DRAIN or mid-GAP, forces reset values immediately. A pending request is discarded.
- Effective ratio: eff = (o_dev_ratio < 2) ? 1 : o_dev_ratio.
- Phase counter cnt (RATIO_W bits) runs only while o_clk_en=1. It counts 0..eff-1 and wraps to 0.
- Boundary = (cnt == eff-1). For eff=1, every cycle is a boundary.
- States: OFF, RUN, DRAIN, GAP.
- OFF:
  - o_clk_en=0; o_req_ready=1.
  - Accepted request: o_dev_ratio <= i_req_ratio on the next edge; o_cfg_done pulses on that same edge (latency 1). No gap is applied.
  - i_div_en=1 → RUN; o_clk_en=1 on the next edge; cnt=0.
  - If i_div_en=1 and a request arrive in the same cycle, both take effect on the same edge.
- RUN:
  - o_clk_en=1; o_req_ready=1.
  - Accepted request with i_req_ratio == o_dev_ratio: o_cfg_done pulses next cycle; state stays RUN; no gap.
  - Accepted request with a different ratio: capture pend_ratio, set pend_ratio_f, → DRAIN.
  - i_div_en=0: set pend_off_f, → DRAIN.
  - Both in the same cycle: both flags are set.
- DRAIN:
  - o_clk_en stays 1; o_req_ready=0; o_busy=1.
  - i_div_en falling during DRAIN sets pend_off_f.
  - i_div_en rising during DRAIN clears pend_off_f.
  - On the boundary cycle → GAP. At that edge: o_clk_en <= 0, cnt <= 0.
  - If pend_ratio_f: o_dev_ratio <= pend_ratio and o_cfg_done pulses at that edge.
  - If the state was entered on a boundary cycle, the transition to GAP is taken on the first boundary after entry, not the entry cycle itself. For eff=1 that is the next cycle.
- GAP:
  - o_clk_en=0; o_req_ready=0; o_busy=1.
  - A GAP_CYCLES-cycle down-counter runs.
  - On expiry: pend_off_f=1 or i_div_en=0 → OFF; otherwise → RUN with o_clk_en=1 next edge.
  - Expiry clears both flags.
- Worst-case latency from request accept to new ratio active: eff + GAP_CYCLES + 1 cycles.

Optional Feature:
- Macro: CLKDIV_CFG_ERR_EN.
- Defined:
  - Requests with i_req_ratio == 0 are acknowledged (ready high) and then discarded.
  - o_req_err pulses on the next cycle.
  - State, o_dev_ratio and pending flags are unchanged.
- Not defined:
  - o_req_err is constant 0.
  - Ratio 0 is accepted like any value and behaves as eff=1 (bypass).

Test Plan:
- Reset: hold i_rst=1 for 20 cycles, then release. Required: o_clk_en=0, o_dev_ratio=4, o_busy=0. On the first cycle after release, o_req_ready=1.
- OFF config: request 8, then i_div_en=1. Required: o_dev_ratio=8 one cycle after accept, o_cfg_done pulse; o_clk_en=1 one cycle after i_div_en.
- Run change: ratio 8 running, request 5 accepted at cnt=2. Required: o_clk_en stays 1 through cnt=7 (6 cycles including accept), then 0 for exactly 2 cycles. o_dev_ratio=5 at the gap start; o_req_ready=0 throughout.
- Same-ratio request 8 while running at 8: o_cfg_done next cycle, o_clk_en never drops.
- Simultaneous i_div_en=0 and request 255 at cnt=0 with ratio 4. Required: 4 drain cycles, then o_dev_ratio=255, 2 gap cycles, final state OFF with o_clk_en=0.
- Reset mid-DRAIN (ratio 127 → 1 pending): o_dev_ratio=4, o_clk_en=0 immediately. With CLKDIV_CFG_ERR_EN, request 0 → o_req_err pulse and o_dev_ratio unchanged.
